// File: rtl/subbytes_engine.sv
// Iterative AES SubBytes / InvSubBytes engine. LANES shared S-box lanes
// substitute one byte group per cycle over 16/LANES cycles, with valid/ready on both sides.
module subbytes_engine #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_mode,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_key,
   output logic         out_mode,
   output logic         busy
);

   localparam int ITER  = 16 / LANES;
   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic             armed_q;
   logic [127:0]     data_q;
   logic             mode_q;
   logic [CNT_W-1:0] cnt_q;
   logic             load, step;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0;
      x = a;
      y = b;
      for (int unsigned i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq, acc;
      sq  = a;
      acc = 8'h01;
      for (int unsigned i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b;
      b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   logic [LANES-1:0][7:0] lane_out;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] lane_in, lane_fwd, lane_inv;
      assign lane_in  = data_q[(int'(cnt_q) * LANES + l) * 8 +: 8];
      assign lane_fwd = sbox(lane_in);
      assign lane_inv = inv_sbox(lane_in);
      assign lane_out[l] = mode_q ? lane_inv : lane_fwd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
      end
   end

   // armed_q holds in_ready low until the first edge after reset release.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = armed_q;
            if (in_valid && armed_q) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
      end else if (load) begin
         data_q <= in_key;
         mode_q <= in_mode;
         cnt_q  <= '0;
      end else if (step) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            data_q[(int'(cnt_q) * LANES + int'(l)) * 8 +: 8] <= lane_out[l];
         end
         if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign out_key  = data_q;
   assign out_mode = mode_q;

endmodule

// File: tb/tb_subbytes_engine.sv
// Directed bench for subbytes_engine: table vectors on LANES=4, round trips on
// LANES 1/2/8/16, plus backpressure, mid-run reset and back-to-back streaming.
module tb_subbytes_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance d: 0 -> LANES=4, 1 -> 1, 2 -> 2, 3 -> 8, 4 -> 16
   logic [4:0]        iv = '0, ir, im = '0, ov, ordy = '0, om, bz;
   logic [4:0][127:0] ik = '0, ok;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
      subbytes_engine #(.LANES(L)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(iv[g]), .in_ready(ir[g]), .in_mode(im[g]), .in_key(ik[g]),
         .out_valid(ov[g]), .out_ready(ordy[g]), .out_key(ok[g]), .out_mode(om[g]),
         .busy(bz[g])
      );
   end

   function automatic int iter_of(input int d);
      case (d)
         0: return 4;
         1: return 16;
         2: return 8;
         3: return 2;
         default: return 1;
      endcase
   endfunction

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Runs one block on instance d with out_ready high; call #1 after a posedge.
   task automatic run_txn(input int d, input logic mode, input logic [127:0] key,
                          output logic [127:0] res, output logic rmode, output int lat);
      int w;
      iv[d] = 1'b1; im[d] = mode; ik[d] = key; ordy[d] = 1'b1;
      w = 0;
      while (!ir[d] && w < 20) begin
         @(posedge clk); #1; w++;
      end
      @(posedge clk); #1;
      iv[d] = 1'b0; ik[d] = 'x; im[d] = 1'bx;
      lat = 1;
      while (!ov[d] && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!ov[d]) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout: instance %0d got no out_valid, expected within %0d cycles", d, iter_of(d) + 1);
      end
      res = ok[d]; rmode = om[d];
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic         mode;
      logic [127:0] key;
      logic [127:0] exp;
   } vec_t;

   vec_t tv[8];

   localparam logic [127:0] SEQ_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] SEQ_SUB = 128'h76abd7fe2b670130c56f6bf27b777c63;
   localparam logic [127:0] ALL63   = {16{8'h63}};

   initial begin
      logic [127:0] r1, r2, key, held, exp_k;
      logic         m1, m2, a, v, m;
      logic [127:0] k;
      int           lat, lat2, acc_n, res_n, last_acc;

      tv[0] = '{1'b0, 128'h0, ALL63};
      tv[1] = '{1'b1, ALL63, 128'h0};
      tv[2] = '{1'b1, 128'h000000000000000000000000000000ed, 128'h52525252525252525252525252525253};
      tv[3] = '{1'b0, SEQ_KEY, SEQ_SUB};
      tv[4] = '{1'b1, SEQ_SUB, SEQ_KEY};
      tv[5] = '{1'b0, {16{8'hff}}, {16{8'h16}}};
      tv[6] = '{1'b0, {8{16'h55aa}}, {8{16'hfcac}}};
      tv[7] = '{1'b1, {16{8'h16}}, {16{8'hff}}};

      // Reset state
      #3;
      chk("rst_in_ready", 128'(ir[0]), 128'd0);
      chk("rst_out_valid", 128'(ov[0]), 128'd0);
      chk("rst_busy", 128'(bz[0]), 128'd0);
      chk("rst_out_key", ok[0], 128'd0);
      chk("rst_out_mode", 128'(om[0]), 128'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", 128'(ir[0]), 128'd1);

      // Table vectors on LANES=4
      for (int i = 0; i < 8; i++) begin
         run_txn(0, tv[i].mode, tv[i].key, r1, m1, lat);
         chk($sformatf("vec%0d_key", i), r1, tv[i].exp);
         chk($sformatf("vec%0d_mode", i), 128'(m1), 128'(tv[i].mode));
         chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd5);
      end

      // Round trips on the other lane counts
      for (int d = 1; d < 5; d++) begin
         for (int n = 0; n < 200; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            run_txn(d, 1'b0, key, r1, m1, lat);
            run_txn(d, 1'b1, r1, r2, m2, lat2);
            if (n == 0) begin
               chk($sformatf("rt_lat_fwd_d%0d", d), 128'(lat), 128'(iter_of(d) + 1));
               chk($sformatf("rt_lat_inv_d%0d", d), 128'(lat2), 128'(iter_of(d) + 1));
               chk($sformatf("rt_mode_d%0d", d), 128'({m1, m2}), 128'(2'b01));
            end
            chk($sformatf("rt_d%0d_n%0d", d, n), r2, key);
         end
      end

      // Backpressure on LANES=4: result held, extra in_valid ignored
      iv[0] = 1'b1; im[0] = 1'b0; ik[0] = SEQ_KEY; ordy[0] = 1'b0;
      @(posedge clk); #1;
      ik[0] = {16{8'ha5}}; im[0] = 1'b1;
      lat = 0;
      while (!ov[0] && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      held = ok[0];
      chk("bp_key", held, SEQ_SUB);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("bp_hold_key", ok[0], SEQ_SUB);
         chk("bp_hold_valid_ready", 128'({ov[0], ir[0], om[0]}), 128'(3'b100));
      end
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", 128'({ov[0], ir[0], bz[0]}), 128'(3'b010));
      iv[0] = 1'b0;
      @(posedge clk); #1;
      chk("bp_no_late_accept", 128'(bz[0]), 128'd0);

      // Asynchronous reset mid-RUN on LANES=1 at counter 7
      iv[1] = 1'b1; im[1] = 1'b1; ik[1] = {16{8'h3c}}; ordy[1] = 1'b1;
      @(posedge clk); #1;
      iv[1] = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      chk("mid_run_busy", 128'(bz[1]), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid_busy", 128'({ov[1], bz[1]}), 128'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_txn(1, 1'b0, SEQ_KEY, r1, m1, lat);
      chk("post_rst_key", r1, SEQ_SUB);

      // Back-to-back streaming on LANES=4 with alternating mode
      iv[0] = 1'b1; ordy[0] = 1'b1; im[0] = 1'b0; ik[0] = 128'h0;
      acc_n = 0; res_n = 0; last_acc = 0;
      for (int cyc = 0; cyc < 80 && res_n < 6; cyc++) begin
         a = iv[0] & ir[0]; v = ov[0]; k = ok[0]; m = om[0];
         @(posedge clk); #1;
         if (a) begin
            if (acc_n > 0) chk("b2b_spacing", 128'(cyc - last_acc), 128'd6);
            last_acc = cyc;
            acc_n++;
            if (acc_n >= 6) iv[0] = 1'b0;
            else begin
               im[0] = acc_n[0];
               ik[0] = acc_n[0] ? ALL63 : 128'h0;
            end
         end
         if (v) begin
            exp_k = res_n[0] ? 128'h0 : ALL63;
            chk($sformatf("b2b_key%0d", res_n), k, exp_k);
            chk($sformatf("b2b_mode%0d", res_n), 128'(m), 128'(res_n[0]));
            res_n++;
         end
      end
      chk("b2b_accepts", 128'(acc_n), 128'd6);
      chk("b2b_results", 128'(res_n), 128'd6);
      chk("b2b_drained", 128'({ov[0], bz[0]}), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
